// File: rtl/pwm_meter_if.sv
// pwm_meter_if: groups the PWM input, the enable and the measurement results of pwm_meter.
// Latency: none (wiring only).
// Backpressure: none; results are strobed by meas_valid and held between reports.
// Signals: pwm_in, meas_en (driven by master); freq_out, duty_out, meas_valid, timeout, busy (driven by slave).
interface pwm_meter_if;
    logic        pwm_in;
    logic        meas_en;
    logic [13:0] freq_out;
    logic [7:0]  duty_out;
    logic        meas_valid;
    logic        timeout;
    logic        busy;

    modport master (
        output pwm_in, meas_en,
        input  freq_out, duty_out, meas_valid, timeout, busy
    );

    modport slave (
        input  pwm_in, meas_en,
        output freq_out, duty_out, meas_valid, timeout, busy
    );
endinterface

// File: rtl/pwm_meter.sv
// pwm_meter: measures PWM period and high time, reports frequency (Hz, sat 16383) and duty (%).
// Latency: meas_valid 61 cycles after the synchronized closing rising edge; timeout report 1 cycle after compare.
// Backpressure: none; meas_valid is a one-cycle strobe, freq_out/duty_out/timeout hold between reports.
// Ports: clk, rst (synchronous, active-high); mif (pwm_meter_if.slave): pwm_in, meas_en in;
//        freq_out, duty_out, meas_valid, timeout, busy out.
module pwm_meter #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int CNT_W       = 26,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    pwm_meter_if.slave mif
);
    // H*100 needs 7 bits on top of the counter width.
    localparam int                DD_W          = CNT_W + 7;
    localparam int                STEP_W        = $clog2(DD_W + 1);
    localparam logic [CNT_W-1:0]  FREQ_DIVIDEND = CNT_W'(CLK_FREQ);
    localparam logic [CNT_W-1:0]  TMO_LAST      = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE       = CNT_W'(1);
    localparam logic [STEP_W-1:0] STEP_ONE      = STEP_W'(1);
    localparam logic [STEP_W-1:0] F_LAST        = STEP_W'(CNT_W - 1);
    localparam logic [STEP_W-1:0] D_LAST        = STEP_W'(DD_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_MEAS  = 3'd2,
        S_DIV_F = 3'd3,
        S_DIV_D = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              s1_q, s2_q, s3_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;   // frozen outside MEAS, so it doubles as divisor P
    logic [CNT_W-1:0]  high_q, high_d;       // frozen outside MEAS, so it doubles as H
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [DD_W-1:0]   dq_q, dq_d;           // dividend shifts out the top, quotient shifts in the bottom
    logic [STEP_W-1:0] step_q, step_d;
    logic [13:0]       fres_q, fres_d;
    logic [13:0]       freq_q, freq_d;
    logic [7:0]        duty_q, duty_d;
    logic              valid_q, valid_d;
    logic              tmo_q, tmo_d;

    logic              re, lvl, tmo_hit, fits;
    logic [CNT_W:0]    trial;
    logic [CNT_W-1:0]  rem_step, qf;
    logic [DD_W-1:0]   dq_step, h_x100;

    assign re  = s2_q & ~s3_q;
    assign lvl = s2_q;

    // One restoring-division step shared by both divisions. The remainder is always
    // below P, so the subtraction result fits CNT_W bits whenever the trial fits.
    always_comb begin
        trial    = {rem_q, dq_q[DD_W-1]};
        fits     = (trial >= {1'b0, period_q});
        rem_step = fits ? (trial[CNT_W-1:0] - period_q) : trial[CNT_W-1:0];
        dq_step  = {dq_q[DD_W-2:0], fits};
        qf       = dq_step[CNT_W-1:0];
        h_x100   = DD_W'(high_q) * DD_W'(100);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        high_d   = high_q;
        rem_d    = rem_q;
        dq_d     = dq_q;
        step_d   = step_q;
        fres_d   = fres_q;
        freq_d   = freq_q;
        duty_d   = duty_q;
        valid_d  = 1'b0;
        tmo_d    = tmo_q;
        tmo_hit  = 1'b0;

        if (!mif.meas_en) begin
            // Dropping the enable abandons any measurement without a report.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_ARM;
                    cnt_d   = '0;
                end
                S_ARM: begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (re) begin
                        state_d  = S_MEAS;
                        period_d = CNT_ONE;
                        high_d   = CNT_ONE;
                    end else if (cnt_q == TMO_LAST) begin
                        tmo_hit = 1'b1;
                    end
                end
                S_MEAS: begin
                    if (re) begin
                        // Closing edge: not counted; start frequency division CLK_FREQ / P.
                        state_d = S_DIV_F;
                        rem_d   = '0;
                        dq_d    = {FREQ_DIVIDEND, 7'd0};
                        step_d  = '0;
                    end else if (period_q == TMO_LAST) begin
                        tmo_hit = 1'b1;
                    end else begin
                        period_d = period_q + CNT_ONE;
                        high_d   = high_q + CNT_W'(lvl);
                    end
                end
                S_DIV_F: begin
                    rem_d  = rem_step;
                    dq_d   = dq_step;
                    step_d = step_q + STEP_ONE;
                    if (step_q == F_LAST) begin
                        fres_d  = (|qf[CNT_W-1:14]) ? 14'h3FFF : qf[13:0];
                        rem_d   = '0;
                        dq_d    = h_x100;
                        step_d  = '0;
                        state_d = S_DIV_D;
                    end
                end
                S_DIV_D: begin
                    rem_d  = rem_step;
                    dq_d   = dq_step;
                    step_d = step_q + STEP_ONE;
                    if (step_q == D_LAST) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    // Duty quotient never exceeds 100, so the low byte is the whole result.
                    freq_d  = fres_q;
                    duty_d  = dq_q[7:0];
                    valid_d = 1'b1;
                    tmo_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_ARM;
                end
                default: state_d = S_IDLE;
            endcase

            if (tmo_hit) begin
                freq_d  = '0;
                duty_d  = lvl ? 8'd100 : 8'd0;
                tmo_d   = 1'b1;
                valid_d = 1'b1;
                cnt_d   = '0;
                state_d = S_ARM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            cnt_q    <= '0;
            period_q <= '0;
            high_q   <= '0;
            rem_q    <= '0;
            dq_q     <= '0;
            step_q   <= '0;
            fres_q   <= '0;
            freq_q   <= '0;
            duty_q   <= '0;
            valid_q  <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= mif.pwm_in;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            high_q   <= high_d;
            rem_q    <= rem_d;
            dq_q     <= dq_d;
            step_q   <= step_d;
            fres_q   <= fres_d;
            freq_q   <= freq_d;
            duty_q   <= duty_d;
            valid_q  <= valid_d;
            tmo_q    <= tmo_d;
        end
    end

    assign mif.freq_out   = freq_q;
    assign mif.duty_out   = duty_q;
    assign mif.meas_valid = valid_q;
    assign mif.timeout    = tmo_q;
    assign mif.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_pwm_meter.sv
// tb_pwm_meter: drives periodic / constant PWM into pwm_meter and checks reports against arithmetic expectations.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_pwm_meter;
    localparam int CLK_FREQ = 1_000_000;
    localparam int CNT_W    = 26;
    localparam int TMO      = 2000;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Waveform generator controls: mode 0 periodic, 1 constant high, 2 constant low.
    int gen_mode    = 0;
    int gen_h       = 300;
    int gen_l       = 700;
    int gen_periods = 0;
    int last_rise   = 0;

    pwm_meter_if mif();

    pwm_meter #(
        .CLK_FREQ   (CLK_FREQ),
        .CNT_W      (CNT_W),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mif(mif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Each period is high for gen_h cycles then low for gen_l; new settings take effect at a period start.
    initial begin : gen
        int pos;
        int cur_h;
        int cur_p;
        pos = 0;
        cur_h = 1;
        cur_p = 2;
        mif.pwm_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (gen_mode == 1) begin
                mif.pwm_in = 1'b1;
                pos = 0;
            end else if (gen_mode == 2) begin
                mif.pwm_in = 1'b0;
                pos = 0;
            end else begin
                if (pos == 0) begin
                    cur_h = gen_h;
                    cur_p = gen_h + gen_l;
                    gen_periods++;
                    last_rise = cyc;
                end
                mif.pwm_in = (pos < cur_h);
                pos = (pos + 1 == cur_p) ? 0 : pos + 1;
            end
        end
    end

    initial begin : watchdog
        #950000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    function automatic int exp_freq(input int p);
        int q;
        q = CLK_FREQ / p;
        return (q > 16383) ? 16383 : q;
    endfunction

    function automatic int exp_duty(input int h, input int p);
        return (h * 100) / p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget, output bit ok, output int n);
        ok = 1'b0;
        n = 0;
        while (!ok && n < budget) begin
            @(negedge clk);
            n++;
            if (mif.meas_valid === 1'b1) ok = 1'b1;
        end
        chk({tag, "_valid_seen"}, 32'(ok), 1);
    endtask

    task automatic wait_rises(input int k);
        int snap;
        int n;
        snap = gen_periods;
        n = 0;
        while (gen_periods < snap + k && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("rise_wait", 32'(gen_periods >= snap + k), 1);
    endtask

    // Disable, switch waveform, re-enable right after the first period of the new waveform starts.
    task automatic set_pattern(input int h, input int l);
        @(negedge clk);
        mif.meas_en = 1'b0;
        gen_mode = 0;
        gen_h = h;
        gen_l = l;
        wait_rises(1);
        mif.meas_en = 1'b1;
    endtask

    task automatic meas_check(input string tag, input int h, input int l, input bit check_lat);
        bit ok;
        int n;
        int p;
        p = h + l;
        wait_valid(tag, 3 * p + 200, ok, n);
        if (ok) begin
            // Drive-to-sample: one cycle into s1, one into s2, then 61 cycles to the strobe.
            if (check_lat) chk({tag, "_latency"}, cyc - last_rise, 63);
            chk({tag, "_freq"}, mif.freq_out, exp_freq(p));
            chk({tag, "_duty"}, mif.duty_out, exp_duty(h, p));
            chk({tag, "_timeout"}, mif.timeout, 0);
            @(negedge clk);
            chk({tag, "_strobe_len"}, mif.meas_valid, 0);
        end
    endtask

    task automatic reset_pulse(input string tag);
        rst = 1'b1;
        @(negedge clk);
        chk({tag, "_freq"}, mif.freq_out, 0);
        chk({tag, "_duty"}, mif.duty_out, 0);
        chk({tag, "_valid"}, mif.meas_valid, 0);
        chk({tag, "_timeout"}, mif.timeout, 0);
        chk({tag, "_busy"}, mif.busy, 0);
        rst = 1'b0;
    endtask

    initial begin : main
        bit ok;
        int n;
        int seen;
        int h;
        int l;

        rst = 1'b1;
        mif.meas_en = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_freq", mif.freq_out, 0);
        chk("reset_duty", mif.duty_out, 0);
        chk("reset_valid", mif.meas_valid, 0);
        chk("reset_timeout", mif.timeout, 0);
        chk("reset_busy", mif.busy, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", mif.busy, 0);

        // 1 kHz, 30 %
        set_pattern(300, 700);
        @(negedge clk);
        chk("busy_after_en", mif.busy, 1);
        meas_check("khz30", 300, 700, 1'b1);
        meas_check("khz30_next", 300, 700, 1'b0);

        // Saturation, truncation, minimum period, loop-back settings
        set_pattern(1, 1);
        meas_check("p2", 1, 1, 1'b0);
        set_pattern(1, 2);
        meas_check("p3", 1, 2, 1'b0);
        set_pattern(500, 1000);
        meas_check("p1500", 500, 1000, 1'b0);
        set_pattern(375, 125);
        meas_check("f2000_d75", 375, 125, 1'b0);
        set_pattern(1, 99);
        meas_check("f10000_d1", 1, 99, 1'b0);

        // Random waveforms
        for (int i = 0; i < 8; i++) begin
            h = int'($urandom_range(1, 300));
            l = int'($urandom_range(1, 300));
            set_pattern(h, l);
            meas_check("rand", h, l, 1'b0);
        end

        // Constant high, then constant low: timeout reports
        @(negedge clk);
        mif.meas_en = 1'b0;
        gen_mode = 1;
        repeat (5) @(negedge clk);
        mif.meas_en = 1'b1;
        wait_valid("tmo_high", TMO + 100, ok, n);
        if (ok) begin
            chk("tmo_high_delay", n, TMO + 1);
            chk("tmo_high_freq", mif.freq_out, 0);
            chk("tmo_high_duty", mif.duty_out, 100);
            chk("tmo_high_flag", mif.timeout, 1);
            gen_mode = 2;
            @(negedge clk);
            chk("tmo_high_strobe_len", mif.meas_valid, 0);
            wait_valid("tmo_low", TMO + 100, ok, n);
            if (ok) begin
                chk("tmo_low_interval", n + 1, TMO);
                chk("tmo_low_freq", mif.freq_out, 0);
                chk("tmo_low_duty", mif.duty_out, 0);
                chk("tmo_low_flag", mif.timeout, 1);
            end
        end
        set_pattern(300, 700);
        meas_check("tmo_clear", 300, 700, 1'b0);

        // Gating mid-division: drop enable at E+10
        wait_rises(2);
        repeat (12) @(negedge clk);
        chk("gate_busy_div", mif.busy, 1);
        mif.meas_en = 1'b0;
        @(negedge clk);
        chk("gate_busy_off", mif.busy, 0);
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (mif.meas_valid === 1'b1) seen++;
        end
        chk("gate_no_strobe", seen, 0);
        chk("gate_hold_freq", mif.freq_out, 1000);
        chk("gate_hold_duty", mif.duty_out, 30);
        set_pattern(30, 970);
        meas_check("regate", 30, 970, 1'b0);

        // Reset during MEAS (input low at the time)
        wait_rises(1);
        repeat (200) @(negedge clk);
        chk("rst_meas_busy_before", mif.busy, 1);
        reset_pulse("rst_meas");
        meas_check("after_rst_meas", 30, 970, 1'b0);

        // Reset during DIV_D (E+38)
        wait_rises(2);
        repeat (40) @(negedge clk);
        chk("rst_divd_busy_before", mif.busy, 1);
        reset_pulse("rst_divd");
        meas_check("after_rst_divd", 30, 970, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
